// File: rtl/drum_pkg.sv
// Shared constants, voice state type and LFSR step helper for the drum voice mixer.
package drum_pkg;

  localparam logic [15:0] AMP_INIT  = 16'hFFFF;
  localparam logic [15:0] ENV_FLOOR = 16'h0040;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Element 0 is pad 0 (highest pitch).
  localparam logic [3:0][15:0] PHASE_INC = {16'h0080, 16'h0100, 16'h0200, 16'h0400};

  typedef enum logic {IDLE, PLAY} voice_state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/drum_voice.sv
// One decaying square-wave drum voice; with DRUM_NOISE_EN and NOISE=1 the sign comes from an LFSR.
// Trigger overrides the held state combinationally so a same-cycle tick sees the restarted voice.
module drum_voice
  import drum_pkg::*;
#(
  parameter int SAMPLE_W    = 24,
  parameter int PHASE_W     = 16,
  parameter int DECAY_SHIFT = 6,
`ifdef DRUM_NOISE_EN
  parameter bit NOISE       = 1'b0,
`endif
  parameter logic [PHASE_W-1:0] PHASE_INC_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trig,
  input  logic                tick,
  output logic [SAMPLE_W-1:0] voice,
  output logic                busy
);

  voice_state_t        state, state_eff, state_next;
  logic [PHASE_W-1:0]  phase, phase_eff, phase_next;
  logic [15:0]         amp, amp_eff, amp_dec, amp_next;
  logic [SAMPLE_W-1:0] mag;
  logic                neg;
  logic                step;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      phase <= '0;
      amp   <= '0;
    end else begin
      state <= state_next;
      phase <= phase_next;
      amp   <= amp_next;
    end
  end

  always_comb begin
    state_eff  = trig ? PLAY : state;
    phase_eff  = trig ? '0 : phase;
    amp_eff    = trig ? AMP_INIT : amp;
    amp_dec    = amp_eff - (amp_eff >> DECAY_SHIFT);
    mag        = SAMPLE_W'({amp_eff, 7'b0});
    step       = tick && (state_eff == PLAY);
    state_next = state_eff;
    phase_next = phase_eff;
    amp_next   = amp_eff;
    voice      = '0;
    if (step) begin
      voice      = neg ? (-mag) : mag;
      phase_next = phase_eff + PHASE_INC_VAL;
      amp_next   = amp_dec;
      // Below the floor the decay step rounds to 1 or 0, so retire the voice.
      if (amp_dec < ENV_FLOOR) state_next = IDLE;
    end
  end

`ifdef DRUM_NOISE_EN
  if (NOISE) begin : g_noise
    logic [15:0] lfsr, lfsr_eff;
    assign lfsr_eff = trig ? LFSR_SEED : lfsr;
    assign neg      = lfsr_eff[0];
    always_ff @(posedge clk) begin
      if (reset)     lfsr <= LFSR_SEED;
      else if (step) lfsr <= lfsr_step(lfsr_eff);
      else           lfsr <= lfsr_eff;
    end
  end else begin : g_square
    assign neg = phase_eff[PHASE_W-1];
  end
`else
  assign neg = phase_eff[PHASE_W-1];
`endif

  assign busy = (state == PLAY);

endmodule

// File: rtl/drum_voice_mixer.sv
// Pad-triggered drum voices mixed with saturation into one sample per LRCLK rising edge (1 clk latency).
// Optional DRUM_NOISE_EN turns voice 0 into an LFSR noise snare.
module drum_voice_mixer
  import drum_pkg::*;
#(
  parameter int NUM_PADS    = 4,
  parameter int SAMPLE_W    = 24,
  parameter int PHASE_W     = 16,
  parameter int DECAY_SHIFT = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lrclk,
  input  logic [NUM_PADS-1:0] pad_hit,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_tick,
  output logic [NUM_PADS-1:0] busy
);

  localparam int ACC_W = SAMPLE_W + 2;

  logic                lrclk_q;
  logic [NUM_PADS-1:0] pad_q;
  logic [NUM_PADS-1:0] trig;
  logic                tick;
  logic [SAMPLE_W-1:0] voice [NUM_PADS];
  logic [ACC_W-1:0]    acc;
  logic [SAMPLE_W-1:0] sat;

  assign tick = lrclk & ~lrclk_q;
  assign trig = pad_hit & ~pad_q;

  // Pad history tracks the level even in reset, so pads held through reset do not fire on release.
  always_ff @(posedge clk) begin
    pad_q <= pad_hit;
    if (reset) lrclk_q <= 1'b0;
    else       lrclk_q <= lrclk;
  end

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_voice
    drum_voice #(
      .SAMPLE_W     (SAMPLE_W),
      .PHASE_W      (PHASE_W),
      .DECAY_SHIFT  (DECAY_SHIFT),
`ifdef DRUM_NOISE_EN
      .NOISE        (i == 0),
`endif
      .PHASE_INC_VAL(PHASE_W'(PHASE_INC[i]))
    ) u_voice (
      .clk  (clk),
      .reset(reset),
      .trig (trig[i]),
      .tick (tick),
      .voice(voice[i]),
      .busy (busy[i])
    );
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_PADS; i++)
      acc = acc + {{2{voice[i][SAMPLE_W-1]}}, voice[i]};
    if (acc[ACC_W-1:SAMPLE_W-1] == '0 || acc[ACC_W-1:SAMPLE_W-1] == '1)
      sat = acc[SAMPLE_W-1:0];
    else if (acc[ACC_W-1])
      sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
    else
      sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_out  <= '0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= tick;
      if (tick) sample_out <= sat;
    end
  end

endmodule

// File: tb/tb_drum_voice_mixer.sv
// Scoreboard bench for drum_voice_mixer: a per-cycle behavioural model queues expected samples on each tick.
module tb_drum_voice_mixer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lrclk = 1'b0;
  logic [3:0]  pad_hit = 4'hF;
  logic [23:0] sample_out;
  logic        sample_tick;
  logic [3:0]  busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [23:0] s;
    logic [3:0]  b;
  } exp_t;
  exp_t sb[$];

  localparam logic [15:0] INC [4] = '{16'h0400, 16'h0200, 16'h0100, 16'h0080};

  drum_voice_mixer dut (
    .clk        (clk),
    .reset      (reset),
    .lrclk      (lrclk),
    .pad_hit    (pad_hit),
    .sample_out (sample_out),
    .sample_tick(sample_tick),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: inputs change only at posedge+1, so evaluating here is race-free.
  logic        m_lr_q;
  logic [3:0]  m_pad_q;
  bit          m_play [4];
  logic [15:0] m_phase [4];
  logic [15:0] m_amp [4];
  logic [15:0] m_lfsr;

  always @(posedge clk) begin
    bit         tk;
    bit         neg;
    logic [3:0] tr;
    int         sum;
    int         mag;
    exp_t       e;
    if (reset) begin
      m_lr_q  = 1'b0;
      m_pad_q = pad_hit;
      m_lfsr  = 16'hACE1;
      for (int i = 0; i < 4; i++) begin
        m_play[i] = 0; m_phase[i] = '0; m_amp[i] = '0;
      end
    end else begin
      tk  = lrclk && !m_lr_q;
      tr  = pad_hit & ~m_pad_q;
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        if (tr[i]) begin
          m_play[i] = 1; m_phase[i] = '0; m_amp[i] = 16'hFFFF;
          if (i == 0) m_lfsr = 16'hACE1;
        end
        if (tk && m_play[i]) begin
          neg = m_phase[i][15];
`ifdef DRUM_NOISE_EN
          if (i == 0) neg = m_lfsr[0];
`endif
          mag = int'(m_amp[i]) * 128;
          sum = neg ? sum - mag : sum + mag;
          m_phase[i] = m_phase[i] + INC[i];
          m_amp[i]   = m_amp[i] - (m_amp[i] >> 6);
          if (i == 0) m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
          if (m_amp[i] < 16'h0040) m_play[i] = 0;
        end
      end
      if (tk) begin
        if (sum > 8388607)       e.s = 24'h7FFFFF;
        else if (sum < -8388608) e.s = 24'h800000;
        else                     e.s = sum[23:0];
        for (int i = 0; i < 4; i++) e.b[i] = m_play[i];
        sb.push_back(e);
      end
      m_lr_q  = lrclk;
      m_pad_q = pad_hit;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sample_tick === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_tick got=%h busy=%b", sample_out, busy);
      end else begin
        e = sb.pop_front();
        if (sample_out !== e.s || busy !== e.b) begin
          n_fail++;
          $display("FAIL sb_sample got=%h busy=%b exp=%h busy=%b", sample_out, busy, e.s, e.b);
        end
      end
    end
  end

  // One LRCLK rising edge; the sample must appear exactly one clock after the edge is seen.
  task automatic do_tick(output logic [23:0] s, output logic [3:0] b);
    @(posedge clk); #1 lrclk = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (sample_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_latency got=%b exp=1", sample_tick);
    end
    s = sample_out;
    b = busy;
    lrclk = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1; pad_hit = 4'h0; lrclk = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] s; logic [3:0] b;
    reset = 1'b1; pad_hit = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    n_tests += 3;
    if (sample_out !== 24'h0) begin n_fail++; $display("FAIL reset_sample got=%h exp=0", sample_out); end
    if (busy !== 4'h0)        begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (sample_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", sample_tick); end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 4'h0) begin n_fail++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
    do_tick(s, b);
    n_tests++;
    if (s !== 24'h0) begin n_fail++; $display("FAIL reset_release_sample got=%h exp=0", s); end
    pad_hit = 4'h0;
  endtask

  task automatic test_pad0_decay();
    logic [23:0] s; logic [3:0] b;
    int n;
    pulse_reset();
    @(posedge clk); #1 pad_hit = 4'h1;
    do_tick(s, b);
    n_tests += 2;
`ifdef DRUM_NOISE_EN
    if (s !== 24'h800080) begin n_fail++; $display("FAIL pad0_tick1 got=%h exp=800080", s); end
`else
    if (s !== 24'h7FFF80) begin n_fail++; $display("FAIL pad0_tick1 got=%h exp=7fff80", s); end
`endif
    if (b[0] !== 1'b1) begin n_fail++; $display("FAIL pad0_busy got=%b exp=1", b[0]); end
    do_tick(s, b);
    n_tests++;
    if (s !== 24'h7E0000) begin n_fail++; $display("FAIL pad0_tick2 got=%h exp=7e0000", s); end
    for (int t = 3; t <= 33; t++) do_tick(s, b);
`ifndef DRUM_NOISE_EN
    n_tests++;
    if (s[23] !== 1'b1) begin n_fail++; $display("FAIL pad0_tick33_sign got=%h exp=negative", s); end
`endif
    n = 0;
    while (b[0] === 1'b1 && n < 1000) begin do_tick(s, b); n++; end
    n_tests++;
    if (b[0] !== 1'b0) begin n_fail++; $display("FAIL pad0_decay_timeout busy=%b exp=0", b[0]); end
    do_tick(s, b);
    n_tests++;
    if (s !== 24'h0) begin n_fail++; $display("FAIL pad0_silent got=%h exp=0", s); end
    pad_hit = 4'h0;
  endtask

  task automatic test_saturate();
    logic [23:0] s; logic [3:0] b;
    pulse_reset();
    @(posedge clk); #1 pad_hit = 4'hF;
    do_tick(s, b);
    n_tests += 2;
    if (s !== 24'h7FFFFF) begin n_fail++; $display("FAIL sat_tick1 got=%h exp=7fffff", s); end
    if (b !== 4'hF)       begin n_fail++; $display("FAIL sat_busy got=%b exp=1111", b); end
    for (int t = 0; t < 80; t++) do_tick(s, b);
    pad_hit = 4'h0;
  endtask

  task automatic test_retrigger();
    logic [23:0] s; logic [3:0] b;
    pulse_reset();
    @(posedge clk); #1 pad_hit = 4'h2;
    for (int t = 0; t < 10; t++) do_tick(s, b);
    @(posedge clk); #1 pad_hit = 4'h0;
    @(posedge clk); #1 pad_hit = 4'h2;
    do_tick(s, b);
    n_tests += 2;
    if (s !== 24'h7FFF80) begin n_fail++; $display("FAIL retrig_sample got=%h exp=7fff80", s); end
    if (b !== 4'h2)       begin n_fail++; $display("FAIL retrig_busy got=%b exp=0010", b); end
    pad_hit = 4'h0;
  endtask

  task automatic test_same_cycle();
    pulse_reset();
    @(posedge clk); #1 pad_hit = 4'h4; lrclk = 1'b1;
    @(posedge clk); #1;
    n_tests += 2;
    if (sample_tick !== 1'b1)    begin n_fail++; $display("FAIL same_cycle_tick got=%b exp=1", sample_tick); end
    if (sample_out !== 24'h7FFF80) begin n_fail++; $display("FAIL same_cycle_sample got=%h exp=7fff80", sample_out); end
    lrclk = 1'b0; pad_hit = 4'h0;
  endtask

  task automatic test_reset_mid_play();
    logic [23:0] s; logic [3:0] b;
    pulse_reset();
    @(posedge clk); #1 pad_hit = 4'hF;
    for (int t = 0; t < 5; t++) do_tick(s, b);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    n_tests += 2;
    if (sample_out !== 24'h0) begin n_fail++; $display("FAIL midreset_sample got=%h exp=0", sample_out); end
    if (busy !== 4'h0)        begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    reset = 1'b0; pad_hit = 4'h0;
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      lrclk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) pad_hit = pad_hit ^ 4'($urandom_range(0, 15));
    end
    @(posedge clk); #1 lrclk = 1'b0; pad_hit = 4'h0;
  endtask

  initial begin
    test_reset();
    test_pad0_decay();
    test_saturate();
    test_retrigger();
    test_same_cycle();
    test_reset_mid_play();
    test_back_to_back();
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
